// File: rtl/mux_n.sv
// Registered 1-to-N demultiplexer: each clock writes inData into slot inSel.
// All slots are presented side by side on outData, with slot 0 in the LSBs.
module mux_n #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                             inClock,
  input  logic                             inReset,
  input  logic [DATA_W-1:0]                inData,
  input  logic [SEL_W-1:0]                 inSel,
  output logic [DATA_W*(2**SEL_W)-1:0]     outData
);

  localparam int unsigned N_SLOT = 2**SEL_W;

  // One register per slot, each with its own decoded write strobe
  for (genvar k = 0; k < N_SLOT; k++) begin : genSlot
    logic              wrStrobe;
    logic [DATA_W-1:0] slotQ;

    assign wrStrobe = (inSel == SEL_W'(k));

    always_ff @(posedge inClock or posedge inReset) begin
      if (inReset) begin
        slotQ <= '0;
      end else if (wrStrobe) begin
        slotQ <= inData;
      end
    end

    assign outData[k*DATA_W +: DATA_W] = slotQ;
  end

endmodule

// File: tb/tb_mux_n.sv
// Bench for mux_n: table of hand-derived vectors, a model-driven data sweep,
// and hand-written reset sequences, all checked through an expectation queue.
module tb_mux_n;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned OUT_W  = DATA_W * (2**SEL_W);

  logic              inClock = 1'b0;
  logic              inReset = 1'b0;
  logic [DATA_W-1:0] inData  = '0;
  logic [SEL_W-1:0]  inSel   = '0;
  logic [OUT_W-1:0]  outData;

  int nChecks = 0;
  int nFails  = 0;

  logic [OUT_W-1:0] expQ [$];
  logic [OUT_W-1:0] model;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  sel;
    logic [OUT_W-1:0]  exp;
  } vec_t;

  vec_t vecs [$];

  mux_n #(.DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .inClock (inClock),
    .inReset (inReset),
    .inData  (inData),
    .inSel   (inSel),
    .outData (outData)
  );

  always #5 inClock = ~inClock;

  task automatic check(input string name, input logic [OUT_W-1:0] act,
                       input logic [OUT_W-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: outData=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive at the falling edge, let one rising edge pass, compare at the next falling edge
  task automatic step(input string name, input logic [DATA_W-1:0] d,
                      input logic [SEL_W-1:0] s, input logic [OUT_W-1:0] exp);
    logic [OUT_W-1:0] e;
    inData = d;
    inSel  = s;
    expQ.push_back(exp);
    @(posedge inClock);
    @(negedge inClock);
    if (expQ.size() == 0) begin
      nChecks++;
      nFails++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = expQ.pop_front();
      check(name, outData, e);
    end
  endtask

  task automatic stepModel(input string name, input logic [DATA_W-1:0] d,
                           input logic [SEL_W-1:0] s);
    if (!inReset) model[int'(s)*DATA_W +: DATA_W] = d;
    step(name, d, s, model);
  endtask

  initial begin
    // Reset asserts before any clock edge and must clear asynchronously
    inReset = 1'b1;
    inData  = 4'hF;
    model   = '0;
    #1;
    check("async_reset_t0", outData, '0);
    @(negedge inClock);

    // Reset held: clock edges ignored
    for (int i = 0; i < 5; i++) begin
      step("reset_hold", 4'hF, SEL_W'(i), 16'h0000);
    end

    inReset = 1'b0;

    vecs.push_back('{4'hA, 2'd2, 16'h0A00});
    vecs.push_back('{4'h1, 2'd0, 16'h0A01});
    vecs.push_back('{4'h1, 2'd0, 16'h0A01});
    vecs.push_back('{4'h1, 2'd1, 16'h0A11});
    vecs.push_back('{4'h1, 2'd1, 16'h0A11});
    vecs.push_back('{4'h1, 2'd2, 16'h0111});
    vecs.push_back('{4'h1, 2'd2, 16'h0111});
    vecs.push_back('{4'h1, 2'd3, 16'h1111});
    vecs.push_back('{4'h1, 2'd3, 16'h1111});
    vecs.push_back('{4'hC, 2'd1, 16'h11C1});
    vecs.push_back('{4'h7, 2'd1, 16'h1171});
    vecs.push_back('{4'h3, 2'd1, 16'h1131});
    vecs.push_back('{4'hE, 2'd3, 16'hE131});

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].data, vecs[i].sel, vecs[i].exp);
    end
    model = 16'hE131;

    // Incrementing data sweeps, two cycles per slot
    for (int d = 0; d < 16; d++) begin
      for (int s = 0; s < 4; s++) begin
        stepModel($sformatf("sweep_d%0d_s%0d_a", d, s), DATA_W'(d), SEL_W'(s));
        stepModel($sformatf("sweep_d%0d_s%0d_b", d, s), DATA_W'(d), SEL_W'(s));
      end
      check($sformatf("sweep_full_d%0d", d), outData, {4{DATA_W'(d)}});
    end

    // Input changes between edges must not be captured
    inData = 4'h9;
    inSel  = 2'd0;
    @(posedge inClock);
    #1;
    inData = 4'h2;
    inSel  = 2'd3;
    @(negedge inClock);
    check("between_edges", outData, 16'hFFF9);
    model = 16'hFFF9;

    for (int s = 0; s < 4; s++) stepModel("fill5", 4'h5, SEL_W'(s));
    check("fill5_done", outData, 16'h5555);

    // Mid-run reset pulse between edges clears before the next edge
    #2;
    inReset = 1'b1;
    #1;
    check("async_reset_mid", outData, 16'h0000);
    model = '0;
    @(negedge inClock);
    check("reset_hold_edge", outData, 16'h0000);
    step("reset_hold_write", 4'h9, 2'd0, 16'h0000);
    inReset = 1'b0;
    step("post_reset_first", 4'h3, 2'd0, 16'h0003);
    step("post_reset_second", 4'h6, 2'd2, 16'h0603);

    if (expQ.size() != 0) begin
      nChecks++;
      nFails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/mux_n.md
# mux_n

Registered 1-to-N demultiplexer (write-slot register bank). Each clock, the data word on `inData` is written into the output slot addressed by `inSel`. All other slots hold their previous contents. `outData` presents every slot side by side, so a narrow serial stream is gathered into a wide parallel word for downstream logic. The default configuration is 4-bit data into four slots, giving a 16-bit output.

## Interface

Parameters:
- `DATA_W`, default 4: width of one data word and of one output slot.
- `SEL_W`, default 2: width of the slot selector; the slot count is `N_SLOT = 2**SEL_W` (4 by default).

Ports:
- `inClock`  in  1  single clock; all state updates on the rising edge.
- `inReset`  in  1  asynchronous, active-high reset.
- `inData`  in  `DATA_W`  word to be written.
- `inSel`  in  `SEL_W`  slot index `k` receiving `inData`.
- `outData`  out  `DATA_W*N_SLOT` (16 by default)  concatenated slots; slot `k` occupies bits `[k*DATA_W +: DATA_W]`, with slot 0 in the LSBs.

## Operation

- Internal state is `N_SLOT` registers of `DATA_W` bits each; `outData` is driven directly from these registers, with no combinational path from the inputs.
- Rising edge with `inReset`=0: slot `inSel` takes `inData`, and every other slot holds its value.
- There is no enable: a write occurs on every clock edge while out of reset.
- Every `inSel` value is a legal slot because `N_SLOT = 2**SEL_W`, so no out-of-range handling is required.
- X/Z on `inSel` is not defined; the bench must drive known values.
- Implement the slot registers with a generate loop over `N_SLOT`, each slot having its own decoded write strobe (`inSel == k`).

## Timing

- Reset: `inReset`=1 clears all slots, so `outData` = 0. The clear takes effect asynchronously, without waiting for a clock edge.
- While `inReset` is held high, `outData` stays 0 and clock edges are ignored.
- Reset deassertion: the first write happens on the first rising edge after `inReset` falls.
- Latency: the value sampled on edge `n` is visible on `outData` after edge `n`, i.e. one cycle.
- `inData` and `inSel` are sampled only at the edge; changes between edges have no effect.
- Simultaneous change of `inData` and `inSel` in the same cycle: the new data is written to the new slot.
- Repeated writes to the same slot: the last write wins, and other slots are unaffected.
- Reset mid-operation: all slots clear immediately, and previously gathered data is discarded.

## Test plan

1. **Reset value:** hold `inReset`=1 for 5 cycles with `inData`=4'hF and `inSel` cycling -> `outData` stays 16'h0000 throughout.
2. **Single-slot write:** release reset, then `inSel`=2, `inData`=4'hA for one edge -> `outData`=16'h0A00 after that edge.
3. **Full sweep:** hold `inData`=4'h1 and step `inSel` 0,1,2,3, two cycles per value -> `outData` reads 16'h0001, 16'h0011, 16'h0111, then 16'h1111.
4. **Incrementing data:** repeat the sweep for each of `inData` = 0..F -> after each 8-cycle sweep, `outData` = {4{inData}`}` (for example 16'h7777 after the `inData`=7 sweep).
5. **Slot isolation:** with `outData`=16'h1111, write 4'hC to slot 1 -> `outData`=16'h11C1, with the other slots unchanged.
6. **Asynchronous reset mid-run:** with `outData`=16'h5555, pulse `inReset` high between edges -> `outData`=0 before the next edge and stays 0 until the first edge after release.
